core_regfile: RTL and testbench
===============================

# core_regfile

Parametrised integer register file for the core: x0 hard-wired to zero, 16 or 32 architectural registers, two registered read ports with hold, one write port, a per-register pending (scoreboard) bit for hazard detection, and a PC register with load/increment. It sits between decode (read/issue side) and writeback (write side) and is the successor to the fixed 32×32 file.

## Interface

Parameters:
- XLEN, 32, data and PC width.
- NREG, 32, number of architectural registers; legal values are 16 (RV32E) or 32.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- CLK  in  1  single clock, all state updates on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- WE  in  1  writeback enable.
- WADDR  in  5  writeback register index.
- WDATA  in  XLEN  writeback data.
- RD_EN  in  1  read strobe; when low, RS1/RS2/RS1_BUSY/RS2_BUSY hold.
- RS1ADDR  in  5  read port 1 index.
- RS1  out  XLEN  read port 1 data, registered.
- RS1_BUSY  out  1  pending bit of RS1ADDR, registered with RS1.
- RS2ADDR  in  5  read port 2 index.
- RS2  out  XLEN  read port 2 data, registered.
- RS2_BUSY  out  1  pending bit of RS2ADDR, registered with RS2.
- ISSUE_WE  in  1  mark ISSUE_ADDR as pending (instruction issued with that rd).
- ISSUE_ADDR  in  5  destination index being issued.
- FLUSH  in  1  clear all pending bits.
- PC_WE  in  1  load PC from PC_WDATA.
- PC_WDATA  in  XLEN  PC load value.
- PC_INC  in  1  PC += 4.
- PC  out  XLEN  program counter.

## Operation

- Valid index: 1 ≤ idx < NREG. Index 0 and indices ≥ NREG are invalid: writes ignored, reads return 0, busy returns 0, issue ignored.
- Write: WE with valid WADDR stores WDATA at the edge.
- Read: when RD_EN=1, RS1 ← reg[RS1ADDR], RS1_BUSY ← pend[RS1ADDR] (same for port 2). When RD_EN=0, outputs hold.
- Pending bits pend[NREG-1:1]:
  - FLUSH=1: all cleared; ISSUE_WE ignored that cycle; WE still writes data.
  - Else set on ISSUE_WE with valid ISSUE_ADDR; cleared on WE with valid WADDR.
  - Issue and writeback to the same index in the same cycle: set wins (newer producer outstanding).
- Same-cycle issue is not visible to reads in that cycle (busy is sampled from pre-update state).
- PC: PC_WE has priority over PC_INC; PC_INC adds 4 modulo 2^XLEN (wraps to 0 from 2^XLEN−4); neither → hold.

## Timing

- Reset (RST=1 at edge): all registers 0, all pending bits 0, RS1=RS2=0, RS1_BUSY=RS2_BUSY=0, PC=RESET_PC. Reset mid-operation discards any same-cycle write, issue or PC update.
- Read latency: 1 cycle (address at edge N, data valid after edge N).
- Write latency: written value readable from reg array on the next edge's read (see Configuration for same-cycle).
- PC update visible 1 cycle after PC_WE/PC_INC.

## Configuration

- CORE_REGFILE_BYPASS_EN defined: write-to-read forwarding. When RD_EN=1 and WE with valid WADDR equal to RSxADDR in the same cycle, RSx ← WDATA and RSx_BUSY ← 0 (unless the same cycle's issue targets it: still 0, since issue is not visible).
- Not defined: same-cycle read returns the old stored value and the old pending bit; new value visible from the next read.

## Test plan

- Reset then read x0..x31 with RD_EN=1 → all RS1/RS2=0, busy=0, PC=RESET_PC.
- Write x5=0xDEADBEEF, next cycle read RS1ADDR=5, RS2ADDR=0 → RS1=0xDEADBEEF, RS2=0; write to x0 then read x0 → 0.
- Same-cycle WE x7=0x1234 and read x7 (old 0): with CORE_REGFILE_BYPASS_EN → RS1=0x1234, busy=0; without → RS1=0, then 0x1234 next read.
- ISSUE x9, read x9 → BUSY=1; WE x9 → BUSY=0 next read; ISSUE and WE x9 same cycle → BUSY=1 after; FLUSH with ISSUE x3 → all busy 0.
- NREG=16: write x20=0xFF, read x20 → 0, busy 0; RD_EN=0 while addresses change → outputs hold.
- PC: PC_WE 0xFFFFFFFC then PC_INC → 0; PC_WE=1 and PC_INC=1 with 0x100 → 0x100; RST mid-increment → RESET_PC.

Source files
------------

// File: rtl/core_regfile.sv
// Integer register file: x0 reads as zero, NREG (16/32) registers, two registered read ports with hold, one write port, pending bits, PC.
// Latency: reads 1 cycle (address at edge N, data after edge N); writes visible to the next edge's read; PC update 1 cycle.
// Backpressure: none; RD_EN low holds RS1/RS2/RS1_BUSY/RS2_BUSY. Optional macro CORE_REGFILE_BYPASS_EN forwards same-cycle writes to reads.
//
// Ports: CLK/RST (sync, active-high); WE/WADDR/WDATA writeback; RD_EN, RS1ADDR/RS1/RS1_BUSY,
// RS2ADDR/RS2/RS2_BUSY read side; ISSUE_WE/ISSUE_ADDR/FLUSH pending-bit control;
// PC_WE/PC_WDATA/PC_INC/PC program counter.
module core_regfile #(
    parameter int unsigned          XLEN     = 32,
    parameter int unsigned          NREG     = 32,
    parameter logic [XLEN-1:0]      RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            WE,
    input  logic [4:0]      WADDR,
    input  logic [XLEN-1:0] WDATA,
    input  logic            RD_EN,
    input  logic [4:0]      RS1ADDR,
    output logic [XLEN-1:0] RS1,
    output logic            RS1_BUSY,
    input  logic [4:0]      RS2ADDR,
    output logic [XLEN-1:0] RS2,
    output logic            RS2_BUSY,
    input  logic            ISSUE_WE,
    input  logic [4:0]      ISSUE_ADDR,
    input  logic            FLUSH,
    input  logic            PC_WE,
    input  logic [XLEN-1:0] PC_WDATA,
    input  logic            PC_INC,
    output logic [XLEN-1:0] PC
);

    // The array is always sized for the full 5-bit index space. Slot 0 and
    // slots >= NREG are never written, so they stay at their reset value of
    // zero and collapse to constants; reads of them are masked anyway.
    localparam int unsigned NSLOT = 32;

    logic [XLEN-1:0]  rf_q [NSLOT];
    logic [XLEN-1:0]  rf_d [NSLOT];
    logic [NSLOT-1:0] pend_q, pend_d;
    logic [XLEN-1:0]  rs1_q, rs1_d, rs2_q, rs2_d;
    logic             rs1_busy_q, rs1_busy_d, rs2_busy_q, rs2_busy_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             wr_hit, iss_hit;

    // An index names a real register only if it is non-zero and below NREG.
    function automatic logic idx_ok(input logic [4:0] idx);
        return (idx != 5'd0) && ({27'd0, idx} < NREG);
    endfunction

    always_comb begin
        rf_d       = rf_q;
        pend_d     = pend_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs1_busy_d = rs1_busy_q;
        rs2_busy_d = rs2_busy_q;
        pc_d       = pc_q;

        wr_hit  = WE && idx_ok(WADDR);
        iss_hit = ISSUE_WE && idx_ok(ISSUE_ADDR);

        if (wr_hit) begin
            rf_d[WADDR] = WDATA;
        end

        // Clear-then-set ordering: when a writeback and a new issue hit the
        // same register, the newer producer is still outstanding.
        if (FLUSH) begin
            pend_d = '0;
        end else begin
            if (wr_hit)  pend_d[WADDR]      = 1'b0;
            if (iss_hit) pend_d[ISSUE_ADDR] = 1'b1;
        end

        // Reads sample pre-update state, so a same-cycle issue is not seen.
        if (RD_EN) begin
            rs1_d      = idx_ok(RS1ADDR) ? rf_q[RS1ADDR]   : '0;
            rs1_busy_d = idx_ok(RS1ADDR) ? pend_q[RS1ADDR] : 1'b0;
            rs2_d      = idx_ok(RS2ADDR) ? rf_q[RS2ADDR]   : '0;
            rs2_busy_d = idx_ok(RS2ADDR) ? pend_q[RS2ADDR] : 1'b0;
`ifdef CORE_REGFILE_BYPASS_EN
            // Forward the writeback; the value being written is final, so
            // the register is no longer busy from this reader's view.
            if (wr_hit && (WADDR == RS1ADDR)) begin
                rs1_d      = WDATA;
                rs1_busy_d = 1'b0;
            end
            if (wr_hit && (WADDR == RS2ADDR)) begin
                rs2_d      = WDATA;
                rs2_busy_d = 1'b0;
            end
`endif
        end

        if (PC_WE) begin
            pc_d = PC_WDATA;
        end else if (PC_INC) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NSLOT; i++) begin
                rf_q[i] <= '0;
            end
            pend_q     <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_busy_q <= 1'b0;
            rs2_busy_q <= 1'b0;
            pc_q       <= RESET_PC;
        end else begin
            rf_q       <= rf_d;
            pend_q     <= pend_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs1_busy_q <= rs1_busy_d;
            rs2_busy_q <= rs2_busy_d;
            pc_q       <= pc_d;
        end
    end

    assign RS1      = rs1_q;
    assign RS2      = rs2_q;
    assign RS1_BUSY = rs1_busy_q;
    assign RS2_BUSY = rs2_busy_q;
    assign PC       = pc_q;

endmodule

// File: tb/tb_core_regfile.sv
// Bench for core_regfile: drives a 32-register and a 16-register instance with identical stimulus.
// Expected outputs come from a behavioural model and are queued per cycle; a negedge monitor pops and compares.
// Directed scenarios first, then randomized traffic including mid-run resets.
module tb_core_regfile;

    localparam logic [31:0] RPC0 = 32'h0000_0080;
    localparam logic [31:0] RPC1 = 32'h0000_0000;
`ifdef CORE_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] rs1;
        logic        b1;
        logic [31:0] rs2;
        logic        b2;
        logic [31:0] pc;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST, WE, RD_EN, ISSUE_WE, FLUSH, PC_WE, PC_INC;
    logic [4:0]  WADDR, RS1ADDR, RS2ADDR, ISSUE_ADDR;
    logic [31:0] WDATA, PC_WDATA;

    logic [31:0] a_rs1, a_rs2, a_pc, b_rs1, b_rs2, b_pc;
    logic        a_b1, a_b2, b_b1, b_b2;

    always #5 CLK = ~CLK;

    core_regfile #(.XLEN(32), .NREG(32), .RESET_PC(RPC0)) u32 (
        .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .RD_EN(RD_EN), .RS1ADDR(RS1ADDR), .RS1(a_rs1), .RS1_BUSY(a_b1),
        .RS2ADDR(RS2ADDR), .RS2(a_rs2), .RS2_BUSY(a_b2),
        .ISSUE_WE(ISSUE_WE), .ISSUE_ADDR(ISSUE_ADDR), .FLUSH(FLUSH),
        .PC_WE(PC_WE), .PC_WDATA(PC_WDATA), .PC_INC(PC_INC), .PC(a_pc));

    core_regfile #(.XLEN(32), .NREG(16), .RESET_PC(RPC1)) u16 (
        .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .RD_EN(RD_EN), .RS1ADDR(RS1ADDR), .RS1(b_rs1), .RS1_BUSY(b_b1),
        .RS2ADDR(RS2ADDR), .RS2(b_rs2), .RS2_BUSY(b_b2),
        .ISSUE_WE(ISSUE_WE), .ISSUE_ADDR(ISSUE_ADDR), .FLUSH(FLUSH),
        .PC_WE(PC_WE), .PC_WDATA(PC_WDATA), .PC_INC(PC_INC), .PC(b_pc));

    // ---------------- reference model ----------------
    logic [31:0] m_rf   [2][32];
    bit          m_pend [2][32];
    logic [31:0] m_pc   [2];
    exp_t        m_out  [2];
    exp_t        q0[$];
    exp_t        q1[$];

    int n_vec = 0;
    int n_bad = 0;

    function automatic bit legal(int k, logic [4:0] a);
        int nreg = (k == 0) ? 32 : 16;
        return (a != 0) && (int'(a) < nreg);
    endfunction

    function automatic logic [31:0] rd_val(int k, logic [4:0] a);
        if (!legal(k, a)) return 32'h0;
        if (BYP && WE && legal(k, WADDR) && WADDR == a) return WDATA;
        return m_rf[k][a];
    endfunction

    function automatic bit rd_busy(int k, logic [4:0] a);
        if (!legal(k, a)) return 1'b0;
        if (BYP && WE && legal(k, WADDR) && WADDR == a) return 1'b0;
        return m_pend[k][a];
    endfunction

    // Advance model instance k by one clock edge using the current inputs.
    task automatic model_step(int k);
        if (RST) begin
            for (int i = 0; i < 32; i++) begin
                m_rf[k][i]   = 32'h0;
                m_pend[k][i] = 1'b0;
            end
            m_out[k] = '{rs1: 32'h0, b1: 1'b0, rs2: 32'h0, b2: 1'b0, pc: 32'h0};
            m_pc[k]  = (k == 0) ? RPC0 : RPC1;
        end else begin
            if (RD_EN) begin
                m_out[k].rs1 = rd_val(k, RS1ADDR);
                m_out[k].b1  = rd_busy(k, RS1ADDR);
                m_out[k].rs2 = rd_val(k, RS2ADDR);
                m_out[k].b2  = rd_busy(k, RS2ADDR);
            end
            if (FLUSH) begin
                for (int i = 0; i < 32; i++) m_pend[k][i] = 1'b0;
            end else begin
                if (WE && legal(k, WADDR))            m_pend[k][WADDR]      = 1'b0;
                if (ISSUE_WE && legal(k, ISSUE_ADDR)) m_pend[k][ISSUE_ADDR] = 1'b1;
            end
            if (WE && legal(k, WADDR)) m_rf[k][WADDR] = WDATA;
            if (PC_WE)       m_pc[k] = PC_WDATA;
            else if (PC_INC) m_pc[k] = m_pc[k] + 32'd4;
        end
        m_out[k].pc = m_pc[k];
    endtask

    // One clock: predict, push after the edge, release inputs off the edge.
    task automatic cyc();
        model_step(0);
        model_step(1);
        @(posedge CLK);
        q0.push_back(m_out[0]);
        q1.push_back(m_out[1]);
        #1;
    endtask

    task automatic idle();
        RST = 0; WE = 0; WADDR = 0; WDATA = 0; RD_EN = 0; RS1ADDR = 0; RS2ADDR = 0;
        ISSUE_WE = 0; ISSUE_ADDR = 0; FLUSH = 0; PC_WE = 0; PC_WDATA = 0; PC_INC = 0;
    endtask

    task automatic rd(logic [4:0] a1, logic [4:0] a2);
        idle(); RD_EN = 1; RS1ADDR = a1; RS2ADDR = a2; cyc();
    endtask

    task automatic wr(logic [4:0] a, logic [31:0] d);
        idle(); WE = 1; WADDR = a; WDATA = d; cyc();
    endtask

    // ---------------- monitor ----------------
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (q0.size() > 0 && q1.size() > 0) begin
                e = q0.pop_front();
                chk("n32.rs1",  a_rs1, e.rs1);
                chk("n32.busy1", {31'd0, a_b1}, {31'd0, e.b1});
                chk("n32.rs2",  a_rs2, e.rs2);
                chk("n32.busy2", {31'd0, a_b2}, {31'd0, e.b2});
                chk("n32.pc",   a_pc,  e.pc);
                e = q1.pop_front();
                chk("n16.rs1",  b_rs1, e.rs1);
                chk("n16.busy1", {31'd0, b_b1}, {31'd0, e.b1});
                chk("n16.rs2",  b_rs2, e.rs2);
                chk("n16.busy2", {31'd0, b_b2}, {31'd0, e.b2});
                chk("n16.pc",   b_pc,  e.pc);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int budget;
        idle();
        RST = 1; cyc(); cyc();

        for (int i = 0; i < 32; i++) rd(5'(i), 5'(31 - i));

        wr(5, 32'hDEADBEEF);
        rd(5, 0);
        wr(0, 32'hCAFEF00D);
        rd(0, 0);

        // Same-cycle write and read of x7 (old value 0).
        idle(); WE = 1; WADDR = 7; WDATA = 32'h1234; RD_EN = 1; RS1ADDR = 7; RS2ADDR = 5; cyc();
        rd(7, 7);

        idle(); ISSUE_WE = 1; ISSUE_ADDR = 9; cyc();
        rd(9, 9);
        wr(9, 32'h99);
        rd(9, 0);
        idle(); ISSUE_WE = 1; ISSUE_ADDR = 9; WE = 1; WADDR = 9; WDATA = 32'h999; cyc();
        rd(9, 9);
        idle(); ISSUE_WE = 1; ISSUE_ADDR = 3; FLUSH = 1; cyc();
        rd(3, 9);

        // Out-of-range for the 16-entry file.
        wr(20, 32'hFF);
        rd(20, 20);
        idle(); ISSUE_WE = 1; ISSUE_ADDR = 20; cyc();
        rd(20, 5);
        for (int i = 0; i < 4; i++) begin
            idle(); RS1ADDR = 5'(i * 3); RS2ADDR = 5'(31 - i); cyc();
        end

        idle(); PC_WE = 1; PC_WDATA = 32'hFFFF_FFFC; cyc();
        idle(); PC_INC = 1; cyc();
        idle(); PC_WE = 1; PC_INC = 1; PC_WDATA = 32'h100; cyc();
        idle(); PC_INC = 1; cyc();
        idle(); PC_INC = 1; RST = 1; WE = 1; WADDR = 5; WDATA = 32'h1; cyc();
        rd(5, 9);

        for (int n = 0; n < 3000; n++) begin
            idle();
            RST        = ($urandom_range(0, 99) < 2);
            WE         = $urandom_range(0, 1);
            WADDR      = 5'($urandom_range(0, 31));
            WDATA      = $urandom;
            RD_EN      = ($urandom_range(0, 3) != 0);
            RS1ADDR    = ($urandom_range(0, 3) == 0) ? WADDR : 5'($urandom_range(0, 31));
            RS2ADDR    = ($urandom_range(0, 3) == 0) ? ISSUE_ADDR : 5'($urandom_range(0, 31));
            ISSUE_WE   = ($urandom_range(0, 9) < 3);
            ISSUE_ADDR = ($urandom_range(0, 4) == 0) ? WADDR : 5'($urandom_range(0, 31));
            FLUSH      = ($urandom_range(0, 19) == 0);
            PC_WE      = ($urandom_range(0, 9) == 0);
            PC_WDATA   = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF8 : $urandom;
            PC_INC     = $urandom_range(0, 1);
            cyc();
        end

        idle();
        budget = 0;
        while ((q0.size() > 0 || q1.size() > 0) && budget < 20) begin
            @(posedge CLK);
            budget++;
        end
        #1;
        if (q0.size() > 0 || q1.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", q0.size() + q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
